// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
//   Drain stage between a parallel FIFO and a board-level serial pin. When the
//   stage is enabled and the FIFO reports data, it strobes the FIFO read once,
//   captures the word on the following cycle, and shifts it out LSB-first as an
//   asynchronous frame: start bit, WIDTH data bits, optional parity bit, and
//   STOP_BITS stop bits, each lasting CLKS_PER_BIT clocks.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous, active-high reset (aborts any frame in flight)
//   en         : stage enable; only gates the start of a new fetch
//   fifo_dor   : FIFO data-out-ready
//   fifo_data  : FIFO output word, valid the cycle after fifo_rd_en
//   fifo_rd_en : one-cycle FIFO read strobe
//   tx         : serial line, idles high
//   busy       : high from the read strobe through the last stop-bit cycle
//   frame_done : one-cycle pulse in the final cycle of the last stop bit
//   tx_count   : completed frames, wraps 255 -> 0
module fifo_serial_tx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_dor,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       tx_count
);

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BAUD_PENULT = 16'(CLKS_PER_BIT - 2);
    localparam logic [7:0]  DATA_LAST   = 8'(WIDTH - 1);
    localparam logic [7:0]  STOP_LAST   = 8'(STOP_BITS - 1);
    localparam logic        ODD_SEL     = (PARITY_ODD != 0);

    state_t             state_reg, state_next;
    logic [15:0]        baud_reg, baud_next;
    logic [7:0]         bit_reg, bit_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic               parity_reg, parity_next;
    logic               tx_reg, tx_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               rd_en_reg, rd_en_next;
    logic [7:0]         count_reg, count_next;
    logic               baud_end;

    assign baud_end = (baud_reg == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            rd_en_reg  <= 1'b0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            rd_en_reg  <= rd_en_next;
            count_reg  <= count_next;
        end
    end

    // Every output is registered, so the *_next values describe what the
    // outputs must show in the cycle after this edge, i.e. in state_next.
    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        tx_next     = 1'b1;
        busy_next   = 1'b1;
        done_next   = 1'b0;
        rd_en_next  = 1'b0;
        // The count steps at the end of the frame_done cycle.
        count_next  = done_reg ? count_reg + 8'd1 : count_reg;

        case (state_reg)
            IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                busy_next = 1'b0;
                if (en && fifo_dor) begin
                    state_next = FETCH;
                    rd_en_next = 1'b1;
                    busy_next  = 1'b1;
                end
            end

            // First FETCH cycle carries the read strobe; the word is only
            // valid on the second, where it is captured.
            FETCH: begin
                baud_next = '0;
                if (!rd_en_reg) begin
                    shift_next  = fifo_data;
                    parity_next = (^fifo_data) ^ ODD_SEL;
                    state_next  = START;
                    tx_next     = 1'b0;
                end
            end

            START: begin
                tx_next = 1'b0;
                if (baud_end) begin
                    baud_next  = '0;
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end

            DATA: begin
                tx_next = shift_reg[0];
                if (baud_end) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_reg == DATA_LAST) begin
                        bit_next = '0;
                        if (PARITY_EN != 0) begin
                            state_next = PARITY;
                            tx_next    = parity_reg;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_next = bit_reg + 8'd1;
                        tx_next  = shift_next[0];
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end

            PARITY: begin
                tx_next = parity_reg;
                if (baud_end) begin
                    baud_next  = '0;
                    state_next = STOP;
                    tx_next    = 1'b1;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end

            STOP: begin
                // Raise frame_done one cycle early so the registered pulse
                // lands on the final stop cycle.
                if ((bit_reg == STOP_LAST) && (baud_reg == BAUD_PENULT)) begin
                    done_next = 1'b1;
                end
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_reg == STOP_LAST) begin
                        bit_next   = '0;
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end else begin
                        bit_next = bit_reg + 8'd1;
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign fifo_rd_en = rd_en_reg;
    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;
    assign tx_count   = count_reg;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx. Two instances share the clock:
//   inst 0: even parity, 1 stop bit;  inst 1: odd parity, 2 stop bits.
// A frame-level model (cycles since the read strobe -> expected line level)
// is compared against every output on every cycle, and directed tests add
// literal expectations for specific frames.
module tb_fifo_serial_tx;

    localparam int CPB = 4;

    logic       clk;
    logic [1:0] rst_s, en_s, dor_s, rd_s, tx_s, busy_s, done_s;
    logic [3:0] data_s [2];
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] allow;

    logic [3:0] q0 [$];
    logic [3:0] q1 [$];

    int checks = 0;
    int errors = 0;
    int pulses [2];

    // model state
    int         pos [2];     // -1 idle, 0 = strobe cycle, 1 = capture cycle, 2.. frame
    logic [3:0] word [2];
    logic [7:0] mcnt [2];
    bit         chk_on [2];
    int         flen [2];
    bit         odd [2];

    fifo_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst_s[0]), .en(en_s[0]), .fifo_dor(dor_s[0]), .fifo_data(data_s[0]),
        .fifo_rd_en(rd_s[0]), .tx(tx_s[0]), .busy(busy_s[0]), .frame_done(done_s[0]), .tx_count(cnt_a));

    fifo_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst_s[1]), .en(en_s[1]), .fifo_dor(dor_s[1]), .fifo_data(data_s[1]),
        .fifo_rd_en(rd_s[1]), .tx(tx_s[1]), .busy(busy_s[1]), .frame_done(done_s[1]), .tx_count(cnt_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %0h, required %0h", name, inst, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] cnt_of(input int i);
        return (i == 0) ? cnt_a : cnt_b;
    endfunction

    // Bench FIFO: registered output that advances on each read strobe.
    always @(posedge clk) begin
        if (rd_s[0] && q0.size() > 0) data_s[0] <= q0.pop_front();
        if (rd_s[1] && q1.size() > 0) data_s[1] <= q1.pop_front();
    end

    always @(negedge clk) begin
        dor_s[0] = allow[0] && (q0.size() > 0);
        dor_s[1] = allow[1] && (q1.size() > 0);
    end

    // Frame model, advanced with the inputs seen at each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_s[i]) begin
                pos[i]    = -1;
                mcnt[i]   = 8'd0;
                chk_on[i] = 1'b1;
            end else if (pos[i] == -1) begin
                if (en_s[i] && dor_s[i]) pos[i] = 0;
            end else if (pos[i] == 1) begin
                word[i] = data_s[i];
                pos[i]  = 2;
            end else if (pos[i] >= 2 && (pos[i] - 2) == flen[i] - 1) begin
                pos[i]  = -1;
                mcnt[i] = mcnt[i] + 8'd1;
            end else begin
                pos[i] = pos[i] + 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic etx, ebusy, erd, edone;
            int q, k;
            if (rd_s[i] === 1'b1) pulses[i]++;
            if (chk_on[i]) begin
                etx = 1'b1; ebusy = 1'b1; erd = 1'b0; edone = 1'b0;
                if (pos[i] == -1) begin
                    ebusy = 1'b0;
                end else if (pos[i] == 0) begin
                    erd = 1'b1;
                end else if (pos[i] >= 2) begin
                    q = pos[i] - 2;
                    k = q / CPB;
                    if (k == 0)      etx = 1'b0;
                    else if (k <= 4) etx = word[i][k-1];
                    else if (k == 5) etx = (^word[i]) ^ odd[i];
                    else             etx = 1'b1;
                    edone = (q == flen[i] - 1);
                end
                chk("model_tx", i, {7'd0, tx_s[i]}, {7'd0, etx});
                chk("model_busy", i, {7'd0, busy_s[i]}, {7'd0, ebusy});
                chk("model_rd_en", i, {7'd0, rd_s[i]}, {7'd0, erd});
                chk("model_done", i, {7'd0, done_s[i]}, {7'd0, edone});
                chk("model_count", i, cnt_of(i), mcnt[i]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input int i);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rd_s[i] === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_rd inst%0d: got no read strobe within 200 cycles, required one", i);
    endtask

    // Called at the negedge of the strobe cycle. seq holds the frame bits in
    // transmission order, first bit in position nb-1. act_kind 1 drops en,
    // 2 drops fifo_dor, at offset act_m.
    task automatic check_frame(input int i, input logic [7:0] seq, input int nb, input int len,
                               input int act_m, input int act_kind);
        for (int m = 1; m <= len + 2; m++) begin
            @(negedge clk);
            if (m == act_m && act_kind == 1) en_s[i] = 1'b0;
            if (m == act_m && act_kind == 2) allow[i] = 1'b0;
            if (m >= 3 && ((m - 3) % CPB) == 0 && ((m - 3) / CPB) < nb)
                chk("frame_bit", i, {7'd0, tx_s[i]}, {7'd0, seq[nb - 1 - (m - 3) / CPB]});
            if (m == len)     chk("done_early", i, {7'd0, done_s[i]}, 8'd0);
            if (m == len + 1) chk("done_last", i, {7'd0, done_s[i]}, 8'd1);
            if (m == len + 2) begin
                chk("idle_busy", i, {7'd0, busy_s[i]}, 8'd0);
                chk("idle_tx", i, {7'd0, tx_s[i]}, 8'd1);
            end
        end
    endtask

    initial begin
        flen[0] = (1 + 4 + 1 + 1) * CPB;   // 28
        flen[1] = (1 + 4 + 1 + 2) * CPB;   // 32
        odd[0] = 1'b0;
        odd[1] = 1'b1;
        pos[0] = -1; pos[1] = -1;
        mcnt[0] = 0; mcnt[1] = 0;
        chk_on[0] = 0; chk_on[1] = 0;
        pulses[0] = 0; pulses[1] = 0;
        data_s[0] = 4'h0; data_s[1] = 4'h0;
        rst_s = 2'b11;
        en_s  = 2'b01;
        allow = 2'b11;
        dor_s = 2'b00;
        q0.push_back(4'b1010);

        // Test 1: reset held with data available
        tick(2);
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx", i, {7'd0, tx_s[i]}, 8'd1);
            chk("rst_rd_en", i, {7'd0, rd_s[i]}, 8'd0);
            chk("rst_busy", i, {7'd0, busy_s[i]}, 8'd0);
            chk("rst_count", i, cnt_of(i), 8'd0);
        end
        rst_s = 2'b00;
        @(negedge clk);
        chk("rd_release_cycle", 0, {7'd0, rd_s[0]}, 8'd0);
        @(negedge clk);
        chk("rd_first_strobe", 0, {7'd0, rd_s[0]}, 8'd1);

        // Test 2: 4'b1010, even parity, 1 stop
        check_frame(0, 8'b0010101, 7, 28, 0, 0);
        chk("count_t2", 0, cnt_a, 8'd1);

        // Test 6: reset inst1 during data bit 2, then a clean frame
        q1.push_back(4'hA);
        en_s[1] = 1'b1;
        wait_rd(1);
        repeat (15) @(negedge clk);
        rst_s[1] = 1'b1;
        @(negedge clk);
        chk("abort_tx", 1, {7'd0, tx_s[1]}, 8'd1);
        chk("abort_busy", 1, {7'd0, busy_s[1]}, 8'd0);
        chk("abort_done", 1, {7'd0, done_s[1]}, 8'd0);
        chk("abort_count", 1, cnt_b, 8'd0);
        rst_s[1] = 1'b0;

        // Test 3: 4'b0111, odd parity (bit 0), 2 stop bits, 32-cycle frame
        q1.push_back(4'b0111);
        wait_rd(1);
        check_frame(1, 8'b01110011, 8, 32, 0, 0);
        chk("count_t3", 1, cnt_b, 8'd1);

        // Test 4: back-to-back 1, F, 6
        q0.push_back(4'h1);
        q0.push_back(4'hF);
        q0.push_back(4'h6);
        wait_rd(0);
        check_frame(0, 8'b0100011, 7, 28, 0, 0);
        @(negedge clk);
        chk("gap_1", 0, {7'd0, rd_s[0]}, 8'd1);
        check_frame(0, 8'b0111101, 7, 28, 0, 0);
        @(negedge clk);
        chk("gap_2", 0, {7'd0, rd_s[0]}, 8'd1);
        check_frame(0, 8'b0011001, 7, 28, 0, 0);
        repeat (10) @(negedge clk);
        chk("pulses_t4", 0, 8'(pulses[0]), 8'd4);
        chk("count_t4", 0, cnt_a, 8'd4);

        // Test 5: en dropped mid-frame, then fifo_dor dropped mid-frame
        q0.push_back(4'h5);
        q0.push_back(4'h9);
        wait_rd(0);
        check_frame(0, 8'b0101001, 7, 28, 10, 1);
        repeat (20) @(negedge clk);
        chk("pulses_en_off", 0, 8'(pulses[0]), 8'd5);
        en_s[0] = 1'b1;
        wait_rd(0);
        check_frame(0, 8'b0100101, 7, 28, 5, 2);
        repeat (5) @(negedge clk);
        allow[0] = 1'b1;
        chk("pulses_t5", 0, 8'(pulses[0]), 8'd6);
        chk("count_t5", 0, cnt_a, 8'd6);
        chk("pulses_inst1", 1, 8'(pulses[1]), 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
